icache_pf_sched: RTL

Prefetch and flush scheduler for the multi-port prefetching instruction cache control path. It accepts prefetch jobs (address, byte length) from NB_REQ requesters, arbitrates them round-robin, and splits each job into CHUNK-aligned chunks. Chunks are issued one at a time on the cache's pf_req/pf_ack/pf_done handshake. Full-cache flush requests from the control registers are interleaved at chunk boundaries.

---
 rtl/icache_pf_sched.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/icache_pf_sched.sv
// icache_pf_sched: prefetch/flush scheduler for the instruction cache.
// Round-robin accepts prefetch jobs from NB_REQ requesters, splits each job
// into CHUNK-aligned commands issued one at a time on the pf_req/pf_ack/pf_done
// handshake, and slots full-cache flushes in at chunk boundaries.
module icache_pf_sched #(
  parameter int NB_REQ = 4,
  parameter int CHUNK  = 128
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NB_REQ-1:0]       req_valid_i,
  input  logic [NB_REQ-1:0][31:0] req_addr_i,
  input  logic [NB_REQ-1:0][15:0] req_len_i,
  output logic [NB_REQ-1:0]       req_ready_o,
  output logic [NB_REQ-1:0]       done_o,
  input  logic                    flush_req_i,
  output logic                    flush_done_o,
  output logic                    pf_req_o,
  output logic [31:0]             pf_addr_o,
  output logic [7:0]              pf_size_o,
  input  logic                    pf_ack_i,
  input  logic                    pf_done_i,
  output logic                    flush_req_o,
  input  logic                    flush_ack_i,
  output logic                    busy_o
);

  localparam int IDX_W = $clog2(NB_REQ);
  localparam int OFF_W = $clog2(CHUNK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_FLUSH
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [31:0]        addr_q, addr_d;
  logic [15:0]        rem_q, rem_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               flush_pend_q, flush_pend_d;
  logic [NB_REQ-1:0]  done_d;
  logic               flush_done_d;

  logic [15:0]        room;
  logic [15:0]        chunk_size;
  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W:0]     cand_sum;
  logic [IDX_W-1:0]   cand;
  logic               exit_evt;
  logic [15:0]        exit_rem;

  // Chunk size: the rest of the job, clipped at the next CHUNK boundary.
  always_comb begin
    room       = 16'(CHUNK) - 16'(addr_q[OFF_W-1:0]);
    chunk_size = (rem_q < room) ? rem_q : room;
  end

  assign pf_addr_o = addr_q;
  assign pf_size_o = chunk_size[7:0];

  // Round-robin search for the first valid requester starting at rr_q.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand_sum = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand_sum >= (IDX_W+1)'(NB_REQ)) begin
        cand_sum = cand_sum - (IDX_W+1)'(NB_REQ);
      end
      cand = cand_sum[IDX_W-1:0];
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Next-state logic and the same-cycle accept handshake. The ready pulse is
  // decided here so that a job is captured on the very edge it is granted and
  // ready can never be seen outside IDLE.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    rr_d         = rr_q;
    flush_pend_d = flush_pend_q | flush_req_i;
    done_d       = '0;
    flush_done_d = 1'b0;
    req_ready_o  = '0;
    exit_evt     = 1'b0;
    exit_rem     = rem_q;

    unique case (state_q)
      S_IDLE: begin
        // A flush arriving this cycle already beats a waiting job.
        if (flush_pend_d) begin
          state_d = S_FLUSH;
        end else if (gnt_found) begin
          req_ready_o[gnt_idx] = rst_ni;
          owner_d = gnt_idx;
          addr_d  = req_addr_i[gnt_idx];
          rem_d   = req_len_i[gnt_idx];
          rr_d    = (gnt_idx == IDX_W'(NB_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          if (req_len_i[gnt_idx] == 16'd0) begin
            done_d[gnt_idx] = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (pf_ack_i) begin
          addr_d  = addr_q + 32'(chunk_size);
          rem_d   = rem_q - chunk_size;
          state_d = S_WAIT_DONE;
          // A done in the ack cycle completes this chunk immediately.
          if (pf_done_i) begin
            exit_evt = 1'b1;
            exit_rem = rem_q - chunk_size;
          end
        end
      end
      S_WAIT_DONE: begin
        if (pf_done_i) begin
          exit_evt = 1'b1;
          exit_rem = rem_q;
        end
      end
      S_FLUSH: begin
        if (flush_ack_i) begin
          flush_done_d = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = (rem_q != 16'd0) ? S_ISSUE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Chunk completion: finish the job, or pick flush vs next chunk.
    if (exit_evt) begin
      if (exit_rem == 16'd0) begin
        done_d[owner_q] = 1'b1;
        state_d         = S_IDLE;
      end else begin
        state_d = flush_pend_d ? S_FLUSH : S_ISSUE;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: the whole control state is reset, so a reset mid-job drops the
    // job outright and no stale done pulse can follow.
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      rr_q         <= '0;
      flush_pend_q <= 1'b0;
      done_o       <= '0;
      flush_done_o <= 1'b0;
      pf_req_o     <= 1'b0;
      flush_req_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      rr_q         <= rr_d;
      flush_pend_q <= flush_pend_d;
      done_o       <= done_d;
      flush_done_o <= flush_done_d;
      pf_req_o     <= (state_d == S_ISSUE);
      flush_req_o  <= (state_d == S_FLUSH);
      busy_o       <= (state_d != S_IDLE) || flush_pend_d;
    end
  end

endmodule
